// File: rtl/enc8b10b_pkg.sv
// Shared 8b10b constants: symbol/char widths, the idle comma and the legal control-character set.
package enc8b10b_pkg;
  localparam int SYM_W  = 10;
  localparam int CHAR_W = 9;

  localparam logic [CHAR_W-1:0] K28_5     = 9'h1BC;
  localparam logic [SYM_W-1:0]  K28_5_RDN = 10'h17C;
  localparam logic [SYM_W-1:0]  K28_5_RDP = 10'h283;

  localparam int NUM_LEGAL_K = 12;
  localparam logic [NUM_LEGAL_K-1:0][7:0] LEGAL_K = {
    8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFC, 8'hDC,
    8'hBC, 8'h9C, 8'h7C, 8'h5C, 8'h3C, 8'h1C
  };

  function automatic logic is_legal_k(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL_K; i++) hit |= (b == LEGAL_K[i]);
    return hit;
  endfunction
endpackage

// File: rtl/encode_8b10b.sv
// Combinational 8b10b encoder; dataout bit order is {j,h,g,f,i,e,d,c,b,a}.
module encode_8b10b
  import enc8b10b_pkg::*;
(
  input  logic [CHAR_W-1:0] datain,
  input  logic              dispin,
  output logic [SYM_W-1:0]  dataout,
  output logic              dispout
);
  logic [4:0] x;
  logic [2:0] y;
  logic       k, k28, unb6, unb4, mid, alt7;
  logic [5:0] t6, c6;
  logic [3:0] t4, c4;

  always_comb begin
    x = datain[4:0];
    y = datain[7:5];
    k = datain[8];
    k28 = k && (x == 5'd28);
    // 5b/6b table in abcdei order, RD- form
    unique case (x)
      5'd0:  t6 = 6'b100111;  5'd1:  t6 = 6'b011101;  5'd2:  t6 = 6'b101101;  5'd3:  t6 = 6'b110001;
      5'd4:  t6 = 6'b110101;  5'd5:  t6 = 6'b101001;  5'd6:  t6 = 6'b011001;  5'd7:  t6 = 6'b111000;
      5'd8:  t6 = 6'b111001;  5'd9:  t6 = 6'b100101;  5'd10: t6 = 6'b010101;  5'd11: t6 = 6'b110100;
      5'd12: t6 = 6'b001101;  5'd13: t6 = 6'b101100;  5'd14: t6 = 6'b011100;  5'd15: t6 = 6'b010111;
      5'd16: t6 = 6'b011011;  5'd17: t6 = 6'b100011;  5'd18: t6 = 6'b010011;  5'd19: t6 = 6'b110010;
      5'd20: t6 = 6'b001011;  5'd21: t6 = 6'b101010;  5'd22: t6 = 6'b011010;  5'd23: t6 = 6'b111010;
      5'd24: t6 = 6'b110011;  5'd25: t6 = 6'b100110;  5'd26: t6 = 6'b010110;  5'd27: t6 = 6'b110110;
      5'd28: t6 = 6'b001110;  5'd29: t6 = 6'b101110;  5'd30: t6 = 6'b011110;  default: t6 = 6'b101011;
    endcase
    if (k28) t6 = 6'b001111;
    unb6 = ($countones(t6) != 3);
    c6 = (dispin && (unb6 || x == 5'd7)) ? ~t6 : t6;
    mid = dispin ^ unb6;

    // Alternate x.7 avoids a run of five equal bits across the e/i..f/g seam
    alt7 = k || (!mid && (x == 5'd17 || x == 5'd18 || x == 5'd20))
              || ( mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    unique case (y)
      3'd0: t4 = 4'b1011;  3'd1: t4 = 4'b1001;  3'd2: t4 = 4'b0101;  3'd3: t4 = 4'b1100;
      3'd4: t4 = 4'b1101;  3'd5: t4 = 4'b1010;  3'd6: t4 = 4'b0110;
      default: t4 = alt7 ? 4'b0111 : 4'b1110;
    endcase
    unb4 = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
    c4 = t4;
    if (mid && (unb4 || y == 3'd3)) c4 = ~t4;
    else if (k28 && !mid && !unb4 && y != 3'd3) c4 = ~t4;

    dataout = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    dispout = dispin ^ unb6 ^ unb4;
  end
endmodule

// File: rtl/serializer_8b10b.sv
// 8b10b serializer: one character per 10 clocks, MSB first, K28.5 idles when nothing is offered.
module serializer_8b10b
  import enc8b10b_pkg::*;
#(
  parameter int                WIDTH     = SYM_W,
  parameter logic [CHAR_W-1:0] IDLE_CHAR = K28_5
)
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CHAR_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              serial_o,
  output logic              sob_o,
  output logic              kerr_o,
  output logic              rd_o
);
  logic [3:0]        cnt;
  logic [WIDTH-1:0]  shift_reg;
  logic              rd, sob, kerr;
  logic              boundary, illegal_k, enc_rd;
  logic [CHAR_W-1:0] enc_in;
  logic [SYM_W-1:0]  enc_out;

  assign boundary  = (cnt == 4'(WIDTH-1));
  assign illegal_k = valid_i && data_i[8] && !is_legal_k(data_i[7:0]);

  // Illegal K is consumed but replaced by the comma so the line stays decodable
  always_comb begin
    enc_in = IDLE_CHAR;
    if (valid_i && !illegal_k) enc_in = data_i;
  end

  encode_8b10b u_enc (
    .datain  (enc_in),
    .dispin  (rd),
    .dataout (enc_out),
    .dispout (enc_rd)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_reg <= '0;
      cnt       <= 4'(WIDTH-1);
      rd        <= 1'b0;
      sob       <= 1'b0;
      kerr      <= 1'b0;
    end else if (boundary) begin
      shift_reg <= enc_out;
      cnt       <= '0;
      rd        <= enc_rd;
      sob       <= 1'b1;
      kerr      <= illegal_k;
    end else begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      cnt       <= cnt + 4'd1;
      sob       <= 1'b0;
      kerr      <= 1'b0;
    end
  end

  assign ready_o  = boundary;
  assign serial_o = shift_reg[WIDTH-1];
  assign sob_o    = sob;
  assign kerr_o   = kerr;
  assign rd_o     = rd;
endmodule

// File: tb/tb_serializer_8b10b.sv
// Randomized scoreboard bench for serializer_8b10b against a table-driven 8b10b reference.
module tb_serializer_8b10b;
  logic       clk = 1'b0, rst = 1'b1;
  logic [8:0] data = '0;
  logic       valid = 1'b0;
  logic       ready, serial, sob, kerr, rd;

  serializer_8b10b dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
    .serial_o(serial), .sob_o(sob), .kerr_o(kerr), .rd_o(rd)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [9:0] sym; logic kerr; logic rd; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int mcnt = 9;
  logic mrd = 1'b0;

  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] T4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [7:0] LK [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal_k(input logic [7:0] b);
    return b inside {8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  endfunction

  // Returns {rd_after, symbol}; sub-block polarity picked to oppose the running disparity
  function automatic logic [10:0] ref_enc(input logic [8:0] c, input logic rd_in);
    logic [5:0] s6;
    logic [3:0] s4;
    logic [9:0] sym;
    logic       r;
    int         x, y;
    x = int'(c[4:0]);
    y = int'(c[7:5]);
    s6 = (c[8] && x == 28) ? 6'b001111 : T6[x];
    if (rd_in && ($countones(s6) != 3 || s6 == 6'b111000)) s6 = ~s6;
    r = rd_in ^ ($countones(s6) != 3);
    if (y == 7 && (c[8] || (s6[1] == s6[0] && s6[0] == !r))) s4 = 4'b0111;
    else s4 = T4[y];
    if (r && ($countones(s4) != 2 || s4 == 4'b1100)) s4 = ~s4;
    else if (!r && c[8] && x == 28 && $countones(s4) == 2 && s4 != 4'b1100) s4 = ~s4;
    for (int b = 0; b < 6; b++) sym[b] = s6[5-b];
    for (int b = 0; b < 4; b++) sym[6+b] = s4[3-b];
    return {($countones(sym) == 5) ? rd_in : !rd_in, sym};
  endfunction

  // Reference: word boundary every 10 cycles, expected symbol queued at the handshake
  initial begin
    logic [8:0]  c;
    logic        bad;
    logic [10:0] res;
    exp_t        e;
    forever begin
      @(posedge clk);
      if (rst) begin
        mcnt = 9; mrd = 1'b0; q.delete();
      end else if (mcnt == 9) begin
        c = valid ? data : 9'h1BC;
        bad = c[8] && !legal_k(c[7:0]);
        if (bad) c = 9'h1BC;
        res = ref_enc(c, mrd);
        mrd = res[10];
        e.sym = res[9:0]; e.kerr = bad; e.rd = mrd;
        q.push_back(e);
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
  end

  // Monitor: assemble each symbol starting at sob and compare with the queue head
  initial begin
    int         bits, idx;
    logic [9:0] s;
    logic       k0, r0;
    exp_t       e;
    bits = 0; idx = 0; s = '0; k0 = 1'b0; r0 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin bits = 0; idx = 0; continue; end
      chk("ready", ready, (mcnt == 9));
      chk("kerr_align", kerr && !sob, 0);
      if (sob) begin
        chk("sob_spacing", bits, 0);
        bits = 0; k0 = kerr; r0 = rd;
      end
      if (sob || bits > 0) begin
        s = {s[8:0], serial};
        bits++;
        if (bits == 10) begin
          bits = 0;
          chk("queue_nonempty", (q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("symbol", s, e.sym);
            chk("kerr", k0, e.kerr);
            chk("rd", r0, e.rd);
            if (idx < 2) chk("first_idle", s, (idx == 0) ? 10'h17C : 10'h283);
            idx++;
          end
        end
      end
    end
  end

  task automatic send(input logic [8:0] c);
    bit got;
    got = 1'b0;
    valid = 1'b1; data = c;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    chk("handshake", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    logic [8:0] c;
    @(negedge clk);
    chk("rst_serial", serial, 0); chk("rst_sob", sob, 0);
    chk("rst_kerr", kerr, 0);     chk("rst_rd", rd, 0);
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    idle(40);

    for (int i = 0; i < 256; i++) send(9'(i));
    idle(25);

    // Pulses only outside the boundary are ignored
    repeat (30) begin
      @(negedge clk);
      valid = !ready; data = 9'($urandom);
    end
    @(negedge clk); valid = 1'b0;
    idle(5);
    send({1'b0, 8'($urandom)});
    idle(25);

    send(9'h100);
    send(9'h0AA);
    idle(15);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ready && !rd) begin found = 1'b1; valid = 1'b1; data = 9'h1FB; end
    end
    chk("k27_7_at_rdn", found, 1);
    @(posedge clk); #1;
    idle(25);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       c = {1'b1, LK[$urandom_range(0, 11)]};
        1:       c = {1'b1, 8'($urandom)};
        default: c = {1'b0, 8'($urandom)};
      endcase
      send(c);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 15));
    end
    idle(25);

    // Asynchronous reset in the middle of a symbol
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (sob) found = 1'b1;
    end
    chk("sob_seen", found, 1);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("mid_rst_serial", serial, 0); chk("mid_rst_rd", rd, 0);
    chk("mid_rst_sob", sob, 0);       chk("mid_rst_kerr", kerr, 0);
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ready, 1);
    idle(35);

    @(negedge clk);
    chk("queue_depth", (q.size() <= 1), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serializer_8b10b.md
Name: serializer_8b10b

Overview:
Transmit-side counterpart of the 8b10b deserializer. It accepts 9-bit characters ({K flag, byte}) over a valid/ready handshake and encodes each one with running disparity through an 8b10b encoder. Each 10-bit symbol is shifted out one bit per clock, MSB first, so it lands in the deserializer's LSB-in shift register in the same order. When no character is offered, the block inserts idle comma K28.5 so the link never stalls and the receiver stays aligned.

Parameters:
WIDTH, 10, symbol width in bits; fixed at 10 for 8b10b; sizes the shift register and bit counter.
IDLE_CHAR, 9'h1BC, {K,byte} inserted when no valid input at a word boundary (K28.5).

Ports:
clk_i  input  1  clock; one serial bit per cycle
rst_i  input  1  asynchronous, active-high reset
data_i  input  9  [8]=K flag, [7:0]=byte; sampled only on handshake
valid_i  input  1  data_i holds a character to send
ready_o  output  1  block takes data_i this cycle if valid_i=1
serial_o  output  1  serial line, registered
sob_o  output  1  high while bit 0 (first bit) of a symbol is on serial_o
kerr_o  output  1  one-cycle pulse, aligned with sob_o, for a substituted illegal K char
rd_o  output  1  current running disparity (0=RD-, 1=RD+)

Behaviour:
- Reset (async, immediate): shift_reg=0, cnt=9, rd=0, kerr=0 → serial_o=0, sob_o=0, kerr_o=0, rd_o=0. ready_o=1 in the first cycle after rst_i deasserts, because cnt=9.
- Counter cnt is 4 bits and runs 0..9. A word boundary is cnt==9. ready_o = (cnt==9), combinational from the register, and does not depend on valid_i.
- At the boundary, each clock:
  - If valid_i is 1, take data_i. Otherwise use IDLE_CHAR.
  - Run the selected char through the encoder with dispin=rd.
  - shift_reg <= dataout, rd <= dispout, cnt <= 0.
- Otherwise, each clock: shift_reg <= {shift_reg[8:0],1'b0}, cnt <= cnt+1.
- serial_o = shift_reg[9]. Symbol bit dataout[9] goes out first; the encoder bit order is {j,h,g,f,i,e,d,c,b,a}.
- Latency: accepted char appears on serial_o the cycle after the handshake. One symbol every 10 cycles; throughput 1 char/10 clk.
- sob_o = (cnt==0), registered.
- Illegal K: K=1 with byte not in {1C,3C,5C,7C,9C,BC,DC,FC,F7,FB,FD,FE}.
  - The block sends IDLE_CHAR instead.
  - kerr_o is asserted for the cnt==0 cycle of that symbol.
  - The character is still consumed, because ready_o was high.
- valid_i held high across boundaries: consecutive chars are taken back-to-back with no idle gap. data_i changes outside ready_o are ignored.
- Idle insertion also updates rd. K28.5 always flips rd.
- Reset mid-symbol: the partial symbol is discarded, rd returns to RD-, and the output restarts with a fresh boundary. The receiver must re-lock on the comma.
- No back-pressure input; the line is always driven.

Decomposition:
- Package enc8b10b_pkg holds:
  - SYM_W=10 and CHAR_W=9.
  - K28_5=9'h1BC.
  - K28_5_RDN=10'h17C and K28_5_RDP=10'h283.
  - Legal-K byte list and an is_legal_k() function.
- Sub-module encode_8b10b is the combinational encoder, mirror of decode_8b10b. Ports: datain[8:0], dispin, dataout[9:0], dispout.
- Top holds the counter, shift register, rd register, handshake and idle/substitution mux.

Test Plan:
- Reset release with valid_i=0 → first symbol 10'h17C (RD-), next 10'h283 (RD+), alternating. rd_o toggles every 10 cycles; sob_o pulses every 10th cycle.
- valid_i=1 continuously, data_i=9'h000..9'h0FF incrementing, looped into deserializer → its outputdata_o matches in order with no idles. code_err_o=0 and disp_err_o=0 throughout.
- valid_i pulsed only when ready_o=0 → nothing accepted, idles only. Pulse coincident with ready_o → exactly one char sent, then idles resume.
- data_i=9'h100 (K0.0, illegal) → 10'h17C or 10'h283 sent per rd, kerr_o=1 on that symbol's sob_o cycle, next char accepted normally.
- data_i=9'h1FB (K27.7) at RD- → legal K sent, kerr_o=0. Deserializer returns 9'h1FB.
- rst_i asserted at cnt=4 → serial_o=0 and rd_o=0 immediately. ready_o=1 the first cycle after release; next symbol is 10'h17C.
